// File: rtl/pc_pkg.sv
// Shared constants for the fetch PC generator:
// PC source codes, FSM encoding, default boot address.
package pc_pkg;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NORM = 2'b11;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [31:0] PC_BOOT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_gen_redirect_sel.sv
// Combinational redirect priority select plus
// branch-target misalignment check.
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int unsigned     C_EXT        = 0
) (
  input  logic [1:0]      pc_src_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-2:0] iaddr_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic [XLEN-1:0] trap_addr_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_addr_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] target;
  logic            tgt_bad;

  assign target  = {iaddr_i, 1'b0};
  assign tgt_bad = (C_EXT == 0) && target[1];

  // A misaligned taken branch is not a redirect.
  always_comb begin
    redirect_valid_o = 1'b0;
    redirect_addr_o  = '0;
    misaligned_o     = 1'b0;
    unique case (1'b1)
      (pc_src_i == PC_SRC_BOOT): begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = BOOT_ADDRESS;
      end
      (pc_src_i == PC_SRC_TRAP): begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = trap_addr_i;
      end
      (pc_src_i == PC_SRC_EPC): begin
        redirect_valid_o = 1'b1;
        redirect_addr_o  = epc_i;
      end
      (pc_src_i == PC_SRC_NORM): begin
        if (branch_taken_i) begin
          misaligned_o     = tgt_bad;
          redirect_valid_o = !tgt_bad;
          redirect_addr_o  = target;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Registered fetch PC with stall-time redirect
// buffering and misaligned-branch detection.
module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS =
    XLEN'(PC_BOOT_DEFAULT),
  parameter int unsigned     C_EXT        = 0,
  parameter int unsigned     INCR         = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            ahb_ready_in,
  input  logic [1:0]      pc_src_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-2:0] iaddr_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] i_addr_out,
  output logic [XLEN-1:0] pc_plus_out,
  output logic            fetch_valid_out,
  output logic            redirect_pending_out,
  output logic            misaligned_instr_out
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            pend_valid_q, pend_valid_d;
  logic            mis_q, mis_d;
  logic [1:0]      state_q, state_d;

  logic            redir;
  logic [XLEN-1:0] redir_addr;
  logic            mis_now;

  pc_redirect_sel #(
    .XLEN         (XLEN),
    .BOOT_ADDRESS (BOOT_ADDRESS),
    .C_EXT        (C_EXT)
  ) u_sel (
    .pc_src_i         (pc_src_in),
    .branch_taken_i   (branch_taken_in),
    .iaddr_i          (iaddr_in),
    .epc_i            (epc_in),
    .trap_addr_i      (trap_address_in),
    .redirect_valid_o (redir),
    .redirect_addr_o  (redir_addr),
    .misaligned_o     (mis_now)
  );

  assign pc_plus_out = pc_q + XLEN'(INCR);

  // Misalignment freezes everything for one cycle;
  // otherwise advance on ready or buffer on stall.
  always_comb begin
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    state_d      = state_q;
    mis_d        = mis_now;
    if (mis_now) begin
      pc_d = pc_q;
    end else if (ahb_ready_in) begin
      if (redir)
        pc_d = redir_addr;
      else if (pend_valid_q)
        pc_d = pend_addr_q;
      else
        pc_d = pc_plus_out;
      pend_valid_d = 1'b0;
      state_d      = ST_RUN;
    end else begin
      if (redir) begin
        pend_addr_d  = redir_addr;
        pend_valid_d = 1'b1;
      end
      if (pend_valid_d)
        state_d = ST_HOLD;
      else if (state_q == ST_BOOT)
        state_d = ST_BOOT;
      else
        state_d = ST_RUN;
    end
  end

  // PC, pending redirect, FSM and pulse registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q         <= BOOT_ADDRESS;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      state_q      <= ST_BOOT;
    end else begin
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      mis_q        <= mis_d;
      state_q      <= state_d;
    end
  end

  assign pc_out               = pc_q;
  assign i_addr_out           = pc_q;
  assign fetch_valid_out      = rst_n_in;
  assign redirect_pending_out = pend_valid_q;
  assign misaligned_instr_out = mis_q;

endmodule
